// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encodings.
// Encoding 2'b11 is unused; the FSM treats it as illegal and recovers to IDLE.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot or auto-reload expiry.
// Load wins over every state; expiry is taken at out==1 so the count never wraps.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  input  logic            enable,
  input  logic            periodic,
  output logic [BITS-1:0] out,
  output logic            busy,
  output logic            done
);

  state_t          r_state;
  state_t          w_state_next;
  logic [BITS-1:0] r_out;
  logic [BITS-1:0] w_out_next;
  logic [BITS-1:0] r_reload;
  logic [BITS-1:0] w_reload_next;
  logic            r_done;
  logic            w_done_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_out    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_out    <= w_out_next;
      r_reload <= w_reload_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_out_next    = r_out;
    w_reload_next = r_reload;
    w_done_next   = 1'b0;
    if (load) begin
      // A zero load parks the timer without a done pulse.
      w_reload_next = load_value;
      w_out_next    = load_value;
      w_state_next  = (load_value != '0) ? RUN : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = IDLE;
        end
        RUN: begin
          if (enable) begin
            if (r_out > BITS'(1)) begin
              w_out_next = r_out - BITS'(1);
            end else if (periodic) begin
              w_out_next  = r_reload;
              w_done_next = 1'b1;
            end else begin
              w_out_next   = '0;
              w_done_next  = 1'b1;
              w_state_next = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          w_out_next   = '0;
          w_state_next = IDLE;
        end
        default: begin
          w_out_next   = '0;
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Directed and randomized bench for down_timer against a cycle-level behavioural model.
module tb_down_timer;

  localparam int BITS = 4;

  logic            clock;
  logic            reset;
  logic            load;
  logic [BITS-1:0] load_value;
  logic            enable;
  logic            periodic;
  logic [BITS-1:0] out;
  logic            busy;
  logic            done;

  down_timer #(.BITS(BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .periodic   (periodic),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Behavioural model: remaining count, last loaded value, running flag.
  int m_out    = 0;
  int m_reload = 0;
  bit m_busy   = 0;
  bit m_done   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},  32'(out),  32'(m_out));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic model_step(input bit ld, input int lv, input bit en, input bit per);
    if (ld) begin
      m_reload = lv;
      m_out    = lv;
      m_busy   = (lv != 0);
      m_done   = 0;
    end else if (m_busy && en) begin
      if (m_out > 1) begin
        m_out  = m_out - 1;
        m_done = 0;
      end else begin
        m_done = 1;
        if (per) m_out = m_reload;
        else begin
          m_out  = 0;
          m_busy = 0;
        end
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_reload = 0; m_busy = 0; m_done = 0;
  endtask

  // Drive inputs for one edge, advance the model, check just after the edge.
  task automatic cycle(input string tag, input bit ld, input int lv, input bit en, input bit per);
    load       = ld;
    load_value = BITS'(lv);
    enable     = en;
    periodic   = per;
    @(posedge clock);
    model_step(ld, lv, en, per);
    #1;
    check_all(tag);
  endtask

  int cnt;
  int dones;
  bit seen;

  initial begin
    reset = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0; periodic = 1'b0;
    #2;
    check_all("reset_cold");
    @(negedge clock);
    reset = 1'b1;

    // One-shot: 5,4,3,2,1,0 then idle holding 0.
    cycle("os_load", 1, 5, 0, 0);
    for (int i = 0; i < 5; i++) cycle("os_run", 0, 0, 1, 0);
    chk("os_done_at_zero", 32'(done), 32'd1);
    cycle("os_idle", 0, 0, 1, 0);
    cycle("os_idle2", 0, 0, 1, 0);

    // Periodic: load 3, 9 enabled cycles.
    cycle("per_load", 1, 3, 0, 1);
    for (int i = 0; i < 9; i++) cycle("per_run", 0, 0, 1, 1);
    chk("per_end_out", 32'(out), 32'd3);

    // Enable gaps: done after exactly 8 clocks.
    cycle("gap_load", 1, 4, 0, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle("gap_run", 0, 0, (i % 2) == 1, 0);
      cnt++;
      if (done) seen = 1;
    end
    chk("gap_clocks", 32'(cnt), 32'd8);

    // Load collision at out==1, then zero load.
    cycle("col_load", 1, 2, 0, 0);
    cycle("col_run", 0, 0, 1, 0);
    cycle("col_hit", 1, 7, 1, 0);
    chk("col_out7", 32'(out), 32'd7);
    cycle("col_run2", 0, 0, 1, 0);
    cycle("zero_load", 1, 0, 1, 0);
    chk("zero_busy", 32'(busy), 32'd0);
    cycle("zero_idle", 0, 0, 1, 1);

    // Wrap extreme: 15 periodic, 45 enabled cycles -> 3 dones.
    cycle("w15_load", 1, 15, 0, 1);
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      cycle("w15_run", 0, 0, 1, 1);
      if (done) dones++;
    end
    chk("w15_dones", 32'(dones), 32'd3);

    // Reload 1 periodic: done continuously high.
    cycle("r1_load", 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle("r1_run", 0, 0, 1, 1);
    chk("r1_done_high", 32'(done), 32'd1);

    // Switch to one-shot mid-count with reload 1: expires next edge.
    cycle("r1_to_os", 0, 0, 1, 0);
    cycle("r1_os_idle", 0, 0, 1, 0);

    // Reset mid-count: asynchronous clear, stays idle after release.
    cycle("rst_load", 1, 9, 0, 0);
    cycle("rst_run", 0, 0, 1, 0);
    cycle("rst_run", 0, 0, 1, 0);
    #2;
    reset = 1'b0;
    load = 1'b0; enable = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (2) begin
      @(posedge clock);
      #1;
      check_all("rst_hold");
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("rst_after", 0, 0, 1, 0);
    cycle("rst_cold_load", 1, 2, 1, 0);
    cycle("rst_cold_run", 0, 0, 1, 0);
    cycle("rst_cold_run", 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            $urandom_range(0, 9) == 0,
            int'($urandom_range(0, (1 << BITS) - 1)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
